// File: rtl/riscy_pkg.sv
// Shared loader constants: FSM state encoding, length-field width and the
// memory-port request bundle used by the port mux.
package riscy_pkg;

    localparam int LEN_BYTES = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [29:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] data;
        logic [3:0]  bsel;
    } mem_req_t;

    function automatic logic is_busy(input logic [2:0] s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Collects LEN_BYTES little-endian bytes into a 32-bit word and strobes
// word_done in the cycle the last byte is accepted.
module byte_to_word_packer
    import riscy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic        word_done
);

    localparam int IDX_W = $clog2(LEN_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN_BYTES - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;

    // Shifting in from the top leaves the first byte in bits [7:0].
    assign word_next = {byte_in, word_q[31:8]};
    assign word_done = byte_en && (idx_q == LAST_IDX);
    assign word      = word_q;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d = '0;
        end else if (byte_en) begin
            idx_d  = idx_q + 1'b1;
            word_d = word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/program_mem_loader.sv
// Loads a length-prefixed program image from a byte stream into program
// memory, holding the CPU in reset and owning the memory port meanwhile.
module program_mem_loader
    import riscy_pkg::*;
#(
    parameter logic [29:0] BASE_WORD_ADDR = 30'h0,
    parameter int          MAX_WORDS      = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [31:2] cpu_address,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_data_in,
    input  logic [3:0]  cpu_byte_select,
    output logic        cpu_stall,
    output logic [31:2] mem_address,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_byte_select,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_reset_hold,
    output logic [15:0] word_count
);

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    logic [2:0]  state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [15:0] wc_q, wc_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        byte_en;
    logic        start_ok;
    logic [15:0] wc_inc;
    logic [31:0] pk_word;
    logic [31:0] pk_next;
    logic        pk_done;

    mem_req_t    loader_req;
    mem_req_t    cpu_req;
    mem_req_t    mem_req;

    assign busy           = is_busy(state_q);
    assign cpu_reset_hold = busy;
    assign byte_ready     = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign byte_en        = byte_valid && byte_ready;
    assign start_ok       = start &&
                            ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign wc_inc         = wc_q + 16'd1;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = wc_q;

    byte_to_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .byte_in   (byte_in),
        .byte_en   (byte_en),
        .word      (pk_word),
        .word_next (pk_next),
        .word_done (pk_done)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wc_d    = wc_q;
        done_d  = done_q;
        error_d = error_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_LEN;
                    wc_d    = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            ST_LEN: begin
                if (pk_done) begin
                    n_d = pk_next;
                    if (pk_next == 32'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (pk_next > MAX_WORDS_W) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pk_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wc_d = wc_inc;
                if ({16'h0, wc_inc} == n_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            wc_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wc_q    <= wc_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        loader_req.addr = BASE_WORD_ADDR + 30'(wc_q);
        loader_req.ren  = 1'b0;
        loader_req.wen  = (state_q == ST_WRITE);
        loader_req.data = pk_word;
        loader_req.bsel = 4'hF;
    end

    // A simultaneous CPU read and write is treated as a read.
    always_comb begin
        cpu_req.addr = cpu_address;
        cpu_req.ren  = cpu_ren;
        cpu_req.wen  = cpu_wen && !cpu_ren;
        cpu_req.data = cpu_data_in;
        cpu_req.bsel = cpu_byte_select;
    end

    assign mem_req         = busy ? loader_req : cpu_req;
    assign mem_address     = mem_req.addr;
    assign mem_ren         = mem_req.ren;
    assign mem_wen         = mem_req.wen;
    assign mem_data_in     = mem_req.data;
    assign mem_byte_select = mem_req.bsel;
    assign cpu_stall       = busy && (cpu_ren || cpu_wen);

endmodule

// File: tb/tb_program_mem_loader.sv
// Randomized self-checking bench for program_mem_loader against an
// image-level model of the expected memory writes.
module tb_program_mem_loader;

    localparam logic [29:0] BASE = 30'h3FFF_FFFF;
    localparam int          MAXW = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:2] cpu_address;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [31:0] cpu_data_in;
    logic [3:0]  cpu_byte_select;
    logic        cpu_stall;
    logic [31:2] mem_address;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_byte_select;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset_hold;
    logic [15:0] word_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] img[$];
    logic [29:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [3:0]  cap_bsel[$];
    logic        cap_ren[$];

    program_mem_loader #(
        .BASE_WORD_ADDR (BASE),
        .MAX_WORDS      (MAXW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .cpu_address     (cpu_address),
        .cpu_ren         (cpu_ren),
        .cpu_wen         (cpu_wen),
        .cpu_data_in     (cpu_data_in),
        .cpu_byte_select (cpu_byte_select),
        .cpu_stall       (cpu_stall),
        .mem_address     (mem_address),
        .mem_ren         (mem_ren),
        .mem_wen         (mem_wen),
        .mem_data_in     (mem_data_in),
        .mem_byte_select (mem_byte_select),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .cpu_reset_hold  (cpu_reset_hold),
        .word_count      (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wen === 1'b1 && busy === 1'b1) begin
            cap_addr.push_back(mem_address);
            cap_data.push_back(mem_data_in);
            cap_bsel.push_back(mem_byte_select);
            cap_ren.push_back(mem_ren);
        end
    end

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_bsel.delete();
        cap_ren.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 ||
            word_count !== 16'd0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_state got busy=%0b done=%0b err=%0b wc=%0d rdy=%0b exp 1 0 0 0 1",
                     busy, done, error, word_count, byte_ready);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap,
                             input bit inj);
        int gap;
        int t;
        gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
            start = inj && (g == 0);
            @(negedge clk);
            start = 1'b0;
        end
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout got ready=%0b exp 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap,
                             input bit inj);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++)
            send_byte(v[8*i +: 8], maxgap, inj);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout got done=%0b exp 1", done);
        end
    endtask

    task automatic check_image(input int nexp, input bit exp_err);
        checks++;
        if (error !== exp_err || busy !== 1'b0 || cpu_reset_hold !== 1'b0) begin
            failures++;
            $display("FAIL end_flags got err=%0b busy=%0b hold=%0b exp err=%0b 0 0",
                     error, busy, cpu_reset_hold, exp_err);
        end
        checks++;
        if (word_count !== 16'(nexp)) begin
            failures++;
            $display("FAIL word_count got=%0d exp=%0d", word_count, nexp);
        end
        checks++;
        if (cap_addr.size() != nexp) begin
            failures++;
            $display("FAIL write_count got=%0d exp=%0d", cap_addr.size(), nexp);
        end else begin
            for (int w = 0; w < nexp; w++) begin
                logic [29:0] ea;
                ea = BASE + 30'(w);
                checks++;
                if (cap_addr[w] !== ea || cap_data[w] !== img[w] ||
                    cap_bsel[w] !== 4'hF || cap_ren[w] !== 1'b0) begin
                    failures++;
                    $display("FAIL write_%0d got a=%h d=%h be=%h r=%0b exp a=%h d=%h be=f r=0",
                             w, cap_addr[w], cap_data[w], cap_bsel[w],
                             cap_ren[w], ea, img[w]);
                end
            end
        end
    endtask

    task automatic run_load(input logic [31:0] len, input int maxgap,
                            input bit inj);
        int nexp;
        bit exp_err;
        exp_err = (len > 32'(MAXW));
        nexp = (len == 0 || exp_err) ? 0 : int'(len);
        clear_cap();
        pulse_start();
        send_word(len, maxgap, inj);
        for (int w = 0; w < nexp; w++)
            send_word(img[w], maxgap, inj);
        wait_done();
        check_image(nexp, exp_err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0 || cpu_reset_hold !== 1'b0 ||
            word_count !== 16'd0 || done !== 1'b0 || error !== 1'b0 ||
            mem_wen !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b busy=%0b hold=%0b wc=%0d done=%0b err=%0b wen=%0b exp all 0",
                     byte_ready, busy, cpu_reset_hold, word_count, done,
                     error, mem_wen);
        end
    endtask

    task automatic test_zero_len();
        img.delete();
        run_load(32'd0, 0, 1'b0);
    endtask

    task automatic test_two_words();
        img.delete();
        img.push_back(32'h0000_0013);
        img.push_back(32'h0010_0093);
        run_load(32'd2, 0, 1'b0);
    endtask

    task automatic test_error();
        img.delete();
        run_load(32'h0000_0801, 0, 1'b0);
    endtask

    task automatic test_max_len();
        img.delete();
        for (int i = 0; i < MAXW; i++) img.push_back($urandom);
        run_load(32'(MAXW), 0, 1'b0);
    endtask

    task automatic test_latency();
        clear_cap();
        pulse_start();
        send_word(32'd2, 0, 1'b0);
        send_word(32'hA5A5_0001, 0, 1'b0);
        checks++;
        if (mem_wen !== 1'b1 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL lat_t1 got wen=%0b rdy=%0b exp 1 0", mem_wen, byte_ready);
        end
        @(negedge clk);
        checks++;
        if (mem_wen !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL lat_t2 got wen=%0b rdy=%0b exp 0 1", mem_wen, byte_ready);
        end
        send_word(32'h5A5A_0002, 0, 1'b0);
        wait_done();
        img.delete();
        img.push_back(32'hA5A5_0001);
        img.push_back(32'h5A5A_0002);
        check_image(2, 1'b0);
    endtask

    task automatic test_cpu_port();
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        img.delete();
        img.push_back($urandom);
        clear_cap();
        pulse_start();
        cpu_ren = 1'b1;
        cpu_wen = 1'b1;
        cpu_address = 30'($urandom);
        #1;
        checks++;
        if (cpu_stall !== 1'b1 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
            failures++;
            $display("FAIL load_cpu got stall=%0b ren=%0b wen=%0b exp 1 0 0",
                     cpu_stall, mem_ren, mem_wen);
        end
        send_word(32'd1, 0, 1'b0);
        send_word(img[0], 0, 1'b0);
        wait_done();
        check_image(1, 1'b0);
        a = 30'($urandom);
        d = $urandom;
        be = 4'($urandom);
        cpu_address = a;
        cpu_data_in = d;
        cpu_byte_select = be;
        cpu_ren = 1'b1;
        cpu_wen = 1'b0;
        #1;
        checks++;
        if (mem_address !== a || mem_ren !== 1'b1 || mem_wen !== 1'b0 ||
            cpu_stall !== 1'b0 || mem_data_in !== d || mem_byte_select !== be) begin
            failures++;
            $display("FAIL pass_read got a=%h r=%0b w=%0b st=%0b d=%h be=%h exp a=%h 1 0 0 d=%h be=%h",
                     mem_address, mem_ren, mem_wen, cpu_stall, mem_data_in,
                     mem_byte_select, a, d, be);
        end
        cpu_ren = 1'b0;
        cpu_wen = 1'b1;
        #1;
        checks++;
        if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL pass_write got w=%0b r=%0b st=%0b exp 1 0 0",
                     mem_wen, mem_ren, cpu_stall);
        end
        cpu_ren = 1'b1;
        #1;
        checks++;
        if (mem_wen !== 1'b0 || mem_ren !== 1'b1) begin
            failures++;
            $display("FAIL pass_both got w=%0b r=%0b exp 0 1", mem_wen, mem_ren);
        end
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        img.delete();
        img.push_back($urandom);
        clear_cap();
        pulse_start();
        send_word(32'd3, 0, 1'b0);
        send_word(img[0], 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || cpu_reset_hold !== 1'b0 ||
            word_count !== 16'd0 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got busy=%0b rdy=%0b hold=%0b wc=%0d done=%0b err=%0b exp all 0",
                     busy, byte_ready, cpu_reset_hold, word_count, done, error);
        end
        byte_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        checks++;
        if (cap_addr.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_writes got=%0d busy=%0b exp=1 0",
                     cap_addr.size(), busy);
        end else begin
            checks++;
            if (cap_data[0] !== img[0] || cap_addr[0] !== BASE) begin
                failures++;
                $display("FAIL abort_kept got a=%h d=%h exp a=%h d=%h",
                         cap_addr[0], cap_data[0], BASE, img[0]);
            end
        end
    endtask

    task automatic test_random_gaps();
        for (int it = 0; it < 8; it++) begin
            int n;
            n = (it == 3) ? 0 : $urandom_range(7, 1);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_load(32'(n), 4, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        cpu_address = '0;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        cpu_data_in = '0;
        cpu_byte_select = '0;
        @(negedge clk);
        test_reset();
        test_zero_len();
        test_two_words();
        test_error();
        test_two_words();
        test_latency();
        test_cpu_port();
        test_reset_mid();
        test_random_gaps();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_mem_loader.md
PROGRAM_MEM_LOADER -- requirements
Module: program_mem_loader

Interface
REQ-001 SHALL have parameter BASE_WORD_ADDR, default 30'h0: word address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 2048: largest legal image length in words.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
REQ-006 SHALL have ports byte_in (input, 8) and byte_valid (input, 1): byte stream from the UART receiver.
REQ-007 SHALL have port byte_ready  output  1: the byte is consumed in a cycle where byte_valid and byte_ready are both high.
REQ-008 SHALL have CPU-side ports cpu_address[31:2], cpu_ren, cpu_wen, cpu_data_in[31:0] and cpu_byte_select[3:0] (all inputs), plus cpu_stall (output, 1).
REQ-009 SHALL have memory-side outputs mem_address[31:2], mem_ren, mem_wen, mem_data_in[31:0] and mem_byte_select[3:0], driving the program memory data port.
REQ-010 SHALL have outputs busy, done, error and cpu_reset_hold (1 bit each), and word_count (16 bits).

Function
REQ-011 SHALL implement the states IDLE, LEN, DATA, WRITE and DONE.
REQ-012 IDLE or DONE, on start: SHALL go to LEN, clear the byte index, word_count and error, and clear done.
REQ-013 LEN: SHALL accept 4 bytes, little-endian, as the word length N.
REQ-014 After the 4th LEN byte: N==0 SHALL go to DONE; N>MAX_WORDS SHALL set error and go to DONE; otherwise SHALL go to DATA.
REQ-015 DATA: SHALL accept 4 bytes little-endian into a word register; the 4th byte SHALL cause WRITE on the next cycle.
REQ-016 WRITE (exactly one cycle): SHALL drive mem_wen=1, mem_ren=0, mem_byte_select=4'hF, mem_address=BASE_WORD_ADDR+word_count (30-bit wrap) and mem_data_in=assembled word.
REQ-017 WRITE: SHALL increment word_count; when it reaches N, SHALL go to DONE, else back to DATA.
REQ-018 byte_ready SHALL be high only in LEN and DATA.
REQ-019 busy SHALL be high in LEN, DATA and WRITE; cpu_reset_hold SHALL equal busy.
REQ-020 done SHALL be high in DONE and remain high until the next start or reset.
REQ-021 When busy=0, the mem_* outputs SHALL pass the cpu_* inputs through combinationally, and mem_wen SHALL be forced to 0 if cpu_ren and cpu_wen are both high.
REQ-022 When busy=1, the loader SHALL own the port; outside WRITE it SHALL drive mem_ren=0 and mem_wen=0.
REQ-023 cpu_stall SHALL equal busy AND (cpu_ren OR cpu_wen).
REQ-024 Latency: 4th DATA byte accepted at cycle t -> mem_wen high at t+1 -> byte_ready high again at t+2.
REQ-025 A start pulse while busy SHALL be ignored.
REQ-026 byte_valid gaps of any length SHALL only stall progress; they SHALL NOT corrupt state.

Reset
REQ-027 reset SHALL force IDLE, and clear byte index, word register, N, word_count, done and error; outputs SHALL be byte_ready=0, busy=0, cpu_reset_hold=0, word_count=0.
REQ-028 reset asserted mid-load SHALL abort the load with no further memory writes; words already written remain in memory.

Structure
REQ-029 The state encoding and the LEN_BYTES=4 constant SHALL live in the shared package riscy_pkg.
REQ-030 A single sub-module, byte_to_word_packer (byte index counter plus 32-bit shift register, with a word-complete strobe), SHALL be used in both LEN and DATA.

Verification
REQ-031 Stream 00 00 00 00 -> done after the 4th byte, no mem_wen pulse, word_count=0.
REQ-032 Stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> mem_wen at word 0 with 32'h00000013, then word 1 with 32'h00100093; done=1; word_count=2.
REQ-033 Length 32'h00000801 with MAX_WORDS=2048 -> error=1, done=1, no write.
REQ-034 cpu_ren=1 during a load -> cpu_stall=1 and mem_ren=0; after done -> mem_address tracks cpu_address and cpu_stall=0.
REQ-035 reset asserted after 2 DATA bytes -> next cycle shows IDLE, busy=0, and no mem_wen follows.
REQ-036 byte_valid toggled randomly with start pulsed mid-load -> the image is identical to the gap-free run and start has no effect.
